traffic_light_param: RTL and testbench
======================================

TRAFFIC_LIGHT_PARAM -- requirements
Module: traffic_light_param

Interface
- REQ-001 SHALL have parameter HW_MIN, default 8: minimum highway-green dwell, in cycles.
- REQ-002 SHALL have parameter YEL_T, default 3: yellow dwell for either road, in cycles.
- REQ-003 SHALL have parameter ALLRED_T, default 1: all-red clearance dwell, in cycles.
- REQ-004 SHALL have parameter CR_MIN, default 4: minimum cross-road-green dwell, in cycles.
- REQ-005 SHALL have parameter CR_MAX, default 10: maximum cross-road-green dwell, in cycles.
- REQ-006 SHALL have parameter TMR_W, default 8: timer width, in bits.
- REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
- REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-009 SHALL have port x, input, 1 bit: cross-road vehicle sensor, level.
- REQ-010 SHALL have port ped_req, input, 1 bit: pedestrian request pulse.
- REQ-011 SHALL have port emerg, input, 1 bit: emergency override, level, meaning "highway priority".
- REQ-012 SHALL have port highway, output, 2 bits: highway light.
- REQ-013 SHALL have port cross_road, output, 2 bits: cross-road light.
- REQ-014 SHALL have port walk, output, 1 bit: pedestrian walk indication.
- REQ-015 SHALL have port state_o, output, 3 bits: current FSM state code.

Function
- REQ-016 SHALL encode lights as RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 SHALL never be driven.
- REQ-017 SHALL implement states HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5; codes 6/7 SHALL go to HG next cycle.
- REQ-018 SHALL drive outputs as Moore functions of state:
  - HG: highway GREEN, cross RED
  - HY: highway YELLOW, cross RED
  - AR1/AR2: both RED
  - CG: highway RED, cross GREEN
  - CY: highway RED, cross YELLOW
- REQ-019 SHALL clear timer tmr to 0 on every state change and otherwise increment it, saturating at 2^TMR_W-1; a state's dwell of T cycles means it exits when tmr==T-1.
- REQ-020 SHALL use HG -> HY when tmr>=HW_MIN-1 AND (x OR ped_pend) AND NOT emerg; otherwise HG holds indefinitely.
- REQ-021 SHALL use HY -> AR1 after YEL_T cycles, and AR1 -> CG after ALLRED_T cycles, unless emerg=1 in AR1, in which case AR1 -> HG.
- REQ-022 SHALL use CG -> CY when any of the following holds: emerg=1 (any tmr); tmr==CR_MAX-1; or tmr>=CR_MIN-1 AND x=0 AND walk_act=0.
- REQ-023 SHALL use CY -> AR2 after YEL_T cycles, and AR2 -> HG after ALLRED_T cycles, independent of emerg.
- REQ-024 SHALL, when emerg=1 in HY or CY, complete the yellow normally; no state SHALL ever skip yellow or all-red.
- REQ-025 SHALL set ped_pend on a cycle with ped_req=1 and clear it on CG entry; set and clear on the same cycle SHALL leave it set.
- REQ-026 SHALL load walk_act on CG entry with ped_pend and clear it on CG exit; walk SHALL be 1 only when state==CG AND walk_act=1.
- REQ-027 SHALL require walk_act=1 to hold CG to at least CR_MIN cycles even when x=0, and SHALL let CR_MAX and emerg still terminate CG.
- REQ-028 SHALL have no combinational path from inputs to outputs; all input effects appear one cycle after sampling.
- REQ-029 SHALL treat parameters as legal only when 1<=ALLRED_T, 1<=YEL_T, 1<=CR_MIN<=CR_MAX, 1<=HW_MIN, and all of them <=2^TMR_W-1; behaviour otherwise is undefined.

Reset
- REQ-030 SHALL, on a clk edge with rst=1, load state=HG, tmr=0, ped_pend=0 and walk_act=0, giving highway=GREEN, cross_road=RED, walk=0, state_o=0.
- REQ-031 SHALL let rst override all other inputs, and SHALL let reset asserted in any state (including CG with walk=1) return to HG on the next edge without yellow.

Verification (default parameters; cycle 0 = first edge after rst falls)
- REQ-032 SHALL cover: rst=1 for 2 cycles, then x=0, ped_req=0, emerg=0 for 50 cycles -> state HG throughout, highway=10, cross_road=00, walk=0.
- REQ-033 SHALL cover: x held at 1 from cycle 0 -> HG cycles 0-7, HY 8-10, AR1 11, CG 12-21 (CR_MAX), CY 22-24, AR2 25, HG 26.
- REQ-034 SHALL cover: x=1 for cycles 0-12 only -> CG exactly 4 cycles (12-15), then CY at 16.
- REQ-035 SHALL cover: one-cycle ped_req at cycle 3 with x=0 -> HY at 8, CG 12-15 with walk=1, walk=0 from 16, ped_pend=0 after 12.
- REQ-036 SHALL cover: x=1, emerg raised at cycle 14 (in CG) -> CY 15-17, AR2 18, HG from 19 and held while emerg=1 despite x=1.
- REQ-037 SHALL cover: rst pulsed at cycle 13 (in CG) -> HG at the next edge, walk=0, tmr=0.

Source files
------------

// File: rtl/traffic_light_param.sv
// traffic_light_param
//   Highway / cross-road traffic light controller with pedestrian walk
//   phase and emergency (highway priority) override.
//
//   Parameters
//     HW_MIN   : minimum highway-green dwell (cycles)
//     YEL_T    : yellow dwell for either road (cycles)
//     ALLRED_T : all-red clearance dwell (cycles)
//     CR_MIN   : minimum cross-road-green dwell (cycles)
//     CR_MAX   : maximum cross-road-green dwell (cycles)
//     TMR_W    : dwell timer width (bits)
//
//   Ports
//     clk        : clock, all logic on rising edge
//     rst        : synchronous active-high reset
//     x          : cross-road vehicle sensor (level)
//     ped_req    : pedestrian request (pulse)
//     emerg      : emergency override, highway priority (level)
//     highway    : highway light   (RED=00, YELLOW=01, GREEN=10)
//     cross_road : cross-road light (same encoding)
//     walk       : pedestrian walk indication
//     state_o    : current state code
//
//   All outputs are decoded from registered state only, so every input
//   effect shows up one cycle after it is sampled.
module traffic_light_param #(
    parameter int HW_MIN   = 8,
    parameter int YEL_T    = 3,
    parameter int ALLRED_T = 1,
    parameter int CR_MIN   = 4,
    parameter int CR_MAX   = 10,
    parameter int TMR_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] highway,
    output logic [1:0] cross_road,
    output logic       walk,
    output logic [2:0] state_o
);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    // Last timer value of each dwell: a dwell of T cycles exits at tmr==T-1.
    localparam logic [TMR_W-1:0] HW_LAST  = TMR_W'(HW_MIN - 1);
    localparam logic [TMR_W-1:0] YEL_LAST = TMR_W'(YEL_T - 1);
    localparam logic [TMR_W-1:0] AR_LAST  = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] CRN_LAST = TMR_W'(CR_MIN - 1);
    localparam logic [TMR_W-1:0] CRX_LAST = TMR_W'(CR_MAX - 1);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [TMR_W-1:0]  tmr_reg,   tmr_next;
    logic              ped_pend_reg, ped_pend_next;
    logic              walk_act_reg, walk_act_next;

    logic cg_entry;
    logic cg_exit;
    logic walk_hold;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= HG;
            tmr_reg      <= '0;
            ped_pend_reg <= 1'b0;
            walk_act_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            ped_pend_reg <= ped_pend_next;
            walk_act_reg <= walk_act_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // An active walk keeps CG up for its minimum dwell even with no cars.
    assign walk_hold = walk_act_reg && (tmr_reg < CRN_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HG: begin
                if ((tmr_reg >= HW_LAST) && (x || ped_pend_reg) && !emerg)
                    state_next = HY;
            end
            HY: begin
                // Emergency never cuts a yellow short.
                if (tmr_reg == YEL_LAST)
                    state_next = AR1;
            end
            AR1: begin
                // Emergency during clearance returns the highway to green
                // instead of handing over to the cross road.
                if (emerg)
                    state_next = HG;
                else if (tmr_reg == AR_LAST)
                    state_next = CG;
            end
            CG: begin
                if (emerg || (tmr_reg == CRX_LAST) ||
                    ((tmr_reg >= CRN_LAST) && !x && !walk_hold))
                    state_next = CY;
            end
            CY: begin
                if (tmr_reg == YEL_LAST)
                    state_next = AR2;
            end
            AR2: begin
                if (tmr_reg == AR_LAST)
                    state_next = HG;
            end
            default: state_next = HG;   // unused codes recover to HG
        endcase
    end

    assign cg_entry = (state_next == CG) && (state_reg != CG);
    assign cg_exit  = (state_reg == CG) && (state_next != CG);

    // Timer restarts on every state change, saturates otherwise.
    always_comb begin
        tmr_next = tmr_reg;
        if (state_next != state_reg)
            tmr_next = '0;
        else if (tmr_reg != '1)
            tmr_next = tmr_reg + 1'b1;
    end

    // A request arriving on the CG-entry cycle wins over the clear so it
    // is served on the next cross-road phase.
    always_comb begin
        ped_pend_next = ped_pend_reg;
        if (ped_req)
            ped_pend_next = 1'b1;
        else if (cg_entry)
            ped_pend_next = 1'b0;
    end

    always_comb begin
        walk_act_next = walk_act_reg;
        if (cg_entry)
            walk_act_next = ped_pend_reg;
        else if (cg_exit)
            walk_act_next = 1'b0;
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        highway    = RED;
        cross_road = RED;
        case (state_reg)
            HG:      highway    = GREEN;
            HY:      highway    = YELLOW;
            CG:      cross_road = GREEN;
            CY:      cross_road = YELLOW;
            default: begin
                highway    = RED;
                cross_road = RED;
            end
        endcase
    end

    assign walk    = (state_reg == CG) && walk_act_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_traffic_light_param.sv
module tb_traffic_light_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] highway;
    logic [1:0] cross_road;
    logic       walk;
    logic [2:0] state_o;

    localparam logic [2:0] S_HG = 3'd0, S_HY = 3'd1, S_AR1 = 3'd2,
                           S_CG = 3'd3, S_CY = 3'd4, S_AR2 = 3'd5;

    traffic_light_param dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .highway    (highway),
        .cross_road (cross_road),
        .walk       (walk),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] hw;
        logic [1:0] cr;
        logic       wk;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Light pattern for each state, taken straight from the output table.
    function automatic exp_t make_exp(input logic [2:0] st, input logic wk);
        exp_t e;
        e.st = st;
        e.wk = wk;
        case (st)
            S_HG:    begin e.hw = 2'b10; e.cr = 2'b00; end
            S_HY:    begin e.hw = 2'b01; e.cr = 2'b00; end
            S_CG:    begin e.hw = 2'b00; e.cr = 2'b10; end
            S_CY:    begin e.hw = 2'b00; e.cr = 2'b01; end
            default: begin e.hw = 2'b00; e.cr = 2'b00; end
        endcase
        return e;
    endfunction

    // Nominal timeline with cars waiting the whole time.
    function automatic logic [2:0] busy_state(input int k);
        if (k <= 7)  return S_HG;
        if (k <= 10) return S_HY;
        if (k == 11) return S_AR1;
        if (k <= 21) return S_CG;
        if (k <= 24) return S_CY;
        if (k == 25) return S_AR2;
        return S_HG;
    endfunction

    // Reset for two edges; on return we are at the start of cycle 0.
    task automatic do_reset();
        rst = 1'b1; x = 1'b0; ped_req = 1'b0; emerg = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one cycle of stimulus, push its expectation, compare on the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input int k, input logic r,
                        input logic xi, input logic pi, input logic ei,
                        input logic [2:0] est, input logic ewk);
        exp_t e;
        rst = r; x = xi; ped_req = pi; emerg = ei;
        sb_q.push_back(make_exp(est, ewk));
        @(negedge clk);
        e = sb_q.pop_front();
        check($sformatf("%s c%0d state", tag, k), {5'd0, state_o},    {5'd0, e.st});
        check($sformatf("%s c%0d hw", tag, k),    {6'd0, highway},    {6'd0, e.hw});
        check($sformatf("%s c%0d cr", tag, k),    {6'd0, cross_road}, {6'd0, e.cr});
        check($sformatf("%s c%0d walk", tag, k),  {7'd0, walk},       {7'd0, e.wk});
        $display("%s cycle %0d: state=%0d hw=%b cr=%b walk=%b", tag, k,
                 state_o, highway, cross_road, walk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] st;
        logic       wk;

        // Idle road: highway green forever.
        do_reset();
        for (int k = 0; k < 50; k++)
            step("idle", k, 1'b0, 1'b0, 1'b0, 1'b0, S_HG, 1'b0);

        // Cars always waiting: cross green runs to its maximum.
        do_reset();
        for (int k = 0; k < 28; k++)
            step("busy", k, 1'b0, 1'b1, 1'b0, 1'b0, busy_state(k), 1'b0);

        // Cars leave after cycle 12: cross green ends at minimum dwell.
        do_reset();
        for (int k = 0; k < 23; k++) begin
            if (k <= 12)      st = busy_state(k);
            else if (k <= 15) st = S_CG;
            else if (k <= 18) st = S_CY;
            else if (k == 19) st = S_AR2;
            else              st = S_HG;
            step("gap", k, 1'b0, (k <= 12), 1'b0, 1'b0, st, 1'b0);
        end

        // Single pedestrian request, no cars.
        do_reset();
        for (int k = 0; k < 31; k++) begin
            wk = 1'b0;
            if (k <= 7)       st = S_HG;
            else if (k <= 10) st = S_HY;
            else if (k == 11) st = S_AR1;
            else if (k <= 15) begin st = S_CG; wk = 1'b1; end
            else if (k <= 18) st = S_CY;
            else if (k == 19) st = S_AR2;
            else              st = S_HG;
            step("ped", k, 1'b0, 1'b0, (k == 3), 1'b0, st, wk);
        end

        // Emergency raised in CG: finish yellow/all-red, then hold HG.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (k <= 14)      st = busy_state(k);
            else if (k <= 17) st = S_CY;
            else if (k == 18) st = S_AR2;
            else              st = S_HG;
            step("emerg", k, 1'b0, 1'b1, 1'b0, (k >= 14), st, 1'b0);
        end

        // Reset during walk: straight back to HG, timer restarted.
        do_reset();
        for (int k = 0; k < 28; k++) begin
            wk = 1'b0;
            if (k <= 13) begin
                st = busy_state(k);
                wk = (st == S_CG);
            end
            else if (k <= 21) st = S_HG;
            else if (k <= 24) st = S_HY;
            else if (k == 25) st = S_AR1;
            else              st = S_CG;
            step("rstcg", k, (k == 13), 1'b1, (k == 3), 1'b0, st, wk);
        end

        check("sb_empty", {7'd0, (sb_q.size() != 0)}, 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
